// File: rtl/contrast_box_pkg.sv
// -----------------------------------------------------------------------------
// contrast_box_pkg
// Shared constants and types for the contrast box value reporter:
//   - text record geometry (8 bytes, 4 decimal digits)
//   - ASCII constants used to build the "C=dddd\r\n" record
//   - reporter FSM state encoding
//   - double-dabble digit adjust helper
// -----------------------------------------------------------------------------
package contrast_box_pkg;

    localparam int RECORD_LEN  = 8;
    localparam int DIGIT_COUNT = 4;
    localparam int BCD_W       = 4 * DIGIT_COUNT;

    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SEND
    } state_t;

    // Double-dabble pre-shift correction: any BCD digit of 5 or more gets +3
    // so that the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int d = 0; d < DIGIT_COUNT; d++) begin
            if (r[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contrast_value_fifo.sv
// -----------------------------------------------------------------------------
// contrast_value_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on pop_data while empty=0. A push while full is accepted when a pop happens
// in the same cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   push, push_data   : write request and data
//   pop               : remove head entry (ignored when empty)
//   pop_data          : current head entry
//   full, empty       : occupancy flags
// Parameters: WIDTH (data width), DEPTH (power of two, >= 2)
// -----------------------------------------------------------------------------
module contrast_value_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/contrast_value_reporter.sv
// -----------------------------------------------------------------------------
// contrast_value_reporter
// Captures pwm_on_time updates into a FIFO, converts each value to four ASCII
// decimal digits with an iterative double-dabble, and streams the 8-byte text
// record "C=dddd\r\n" over a byte-wide valid/ready interface.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   value_changed     : one-cycle capture strobe
//   value             : value sampled when value_changed=1
//   tx_data, tx_valid : current record byte and its valid flag
//   tx_ready          : sink accepts tx_data
//   dropped           : saturating count of lost updates (only when the
//                       macro CONTRAST_REPORT_DROP_CNT_EN is defined)
// Parameters: PWM_REG_WIDTH (1..13), FIFO_DEPTH (power of two, >= 2)
// -----------------------------------------------------------------------------
module contrast_value_reporter
    import contrast_box_pkg::*;
#(
    parameter int PWM_REG_WIDTH = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     value_changed,
    input  logic [PWM_REG_WIDTH-1:0] value,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
`ifdef CONTRAST_REPORT_DROP_CNT_EN
    ,
    output logic [7:0]               dropped
`endif
);

    localparam int CNT_W = $clog2(PWM_REG_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = PWM_REG_WIDTH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_LAST = 1;

    state_t                   state;
    state_t                   state_next;
    logic [PWM_REG_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]         bcd_q;
    logic [CNT_W-1:0]         bit_cnt_q;
    logic [2:0]               idx_q;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [PWM_REG_WIDTH-1:0] fifo_head;

    logic [BCD_W+PWM_REG_WIDTH-1:0] dabble_word;
    logic [7:0]                     record_byte;

    // A full FIFO still takes the update when the FSM pops in the same cycle.
    assign fifo_push = value_changed && (!fifo_full || fifo_pop);

    contrast_value_fifo #(
        .WIDTH (PWM_REG_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (value),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from pre-edge values, independent of process order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (bit_cnt_q == CNT_LAST) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = record_byte;
                if (tx_ready && idx_q == 3'd7) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Record byte selection; digits are most significant first.
    always_comb begin
        record_byte = 8'h00;
        case (idx_q)
            3'd0: record_byte = ASCII_C;
            3'd1: record_byte = ASCII_EQ;
            3'd2: record_byte = ASCII_0 + {4'h0, bcd_q[15:12]};
            3'd3: record_byte = ASCII_0 + {4'h0, bcd_q[11:8]};
            3'd4: record_byte = ASCII_0 + {4'h0, bcd_q[7:4]};
            3'd5: record_byte = ASCII_0 + {4'h0, bcd_q[3:0]};
            3'd6: record_byte = ASCII_CR;
            3'd7: record_byte = ASCII_LF;
            default: record_byte = 8'h00;
        endcase
    end

    // One double-dabble step: adjust the BCD digits, then shift the combined
    // {BCD, binary} word left so the next binary MSB enters the BCD units digit.
    assign dabble_word = {dabble_adjust(bcd_q), shift_q} << 1;

    // ---------------------------------------------------------------------
    // Converter and byte index datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        shift_q   <= fifo_head;
                        bcd_q     <= '0;
                        bit_cnt_q <= CNT_INIT;
                    end
                end
                ST_CONVERT: begin
                    {bcd_q, shift_q} <= dabble_word;
                    bit_cnt_q        <= bit_cnt_q - 1'b1;
                    idx_q            <= '0;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: idx_q <= '0;
            endcase
        end
    end

`ifdef CONTRAST_REPORT_DROP_CNT_EN
    // Counts updates that could not be queued; saturates at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped <= 8'h00;
        end else if (value_changed && !fifo_push && dropped != 8'hFF) begin
            dropped <= dropped + 8'h01;
        end
    end
`endif

endmodule
